shift_count: RTL and testbench
==============================

Name: shift_count

Overview:
- Per-axis motion-event accumulator for the stabilisation path.
- Consumes one signed displacement measurement (dx, dy) per valid strobe, classifies each axis as positive/negative/dead-zone, and counts events over a window of frames.
- Once per window it publishes saturated 5-bit counts plus "same magnitude" flags, directly feeding the shift decision stage (inputs dxo_cnt/dxn_cnt/dyo_cnt/dyn_cnt/x_same/y_same).
- Naming: o = positive direction, n = negative direction.

Parameters:
- DW, 8, width of signed dx/dy inputs.
- DEAD_ZONE, 2, magnitude at or below which a measurement is ignored (unsigned, DW bits).
- SAME_TOL, 1, maximum |mag_pos - mag_neg| for the same-flag to assert.
- WIN_FRAMES, 16, frames per accumulation window; legal range 1..31.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  block enable; low forces IDLE
- frame_start  in  1  one-cycle pulse at start of each frame
- meas_vld  in  1  dx/dy valid this cycle
- dx  in  DW  signed two's-complement x displacement
- dy  in  DW  signed two's-complement y displacement
- dxo_cnt  out  5  positive-x event count, last completed window
- dxn_cnt  out  5  negative-x event count
- dyo_cnt  out  5  positive-y event count
- dyn_cnt  out  5  negative-y event count
- x_same  out  1  last positive and last negative x magnitudes match within SAME_TOL
- y_same  out  1  same for y
- cnt_vld  out  1  one-cycle pulse when outputs update

Behaviour:
- Reset (rst_n=0, async):
  - All outputs 0; accumulators, last-magnitude registers and frame counter 0; state IDLE.
  - Reset mid-window discards the partial window.
- States:
  - IDLE -> ARM when en=1.
  - ARM -> ACCUM on first frame_start; frame_cnt=1, accumulators cleared.
  - ACCUM -> IDLE when en=0 (any cycle, takes priority). Accumulators and frame_cnt cleared; outputs hold last published values; no cnt_vld.
- Magnitude: mag = |d| computed in DW+1 bits, so -128 gives 128.
- Classification:
  - Event when mag > DEAD_ZONE.
  - Positive if d>0, negative if d<0.
  - x and y classified independently in the same cycle.
- Accumulate (ACCUM, meas_vld=1):
  - The matching acc increments by 1, saturating at 31.
  - The matching last-magnitude register (mag_xo/mag_xn/mag_yo/mag_yn) loads mag.
  - Dead-zone samples change nothing.
  - meas_vld in ARM or IDLE is ignored.
- Window close, on frame_start in ACCUM with frame_cnt==WIN_FRAMES:
  - Next cycle: dxo_cnt..dyn_cnt <= accumulators, including any event in the close cycle.
  - x_same <= (mag_xo!=0) && (mag_xn!=0) && |mag_xo-mag_xn| <= SAME_TOL, using values including the close-cycle update; y_same likewise.
  - cnt_vld=1 for exactly that one cycle.
  - Accumulators and last-magnitude registers clear; frame_cnt <= 1.
- Other frame_start in ACCUM: frame_cnt += 1.
- Latency: close-cycle frame_start to cnt_vld/outputs = 1 clock.
- Stability: outputs change only with cnt_vld.
- Simultaneous frame_start and meas_vld on a non-close cycle: the sample counts in the current window.
- Output counts never exceed 31; there is no wrap.

Test Plan:
- Reset/IDLE: rst_n low with en=1 and random dx/dy -> all outputs 0, no cnt_vld. Release with en=0 and 40 frames -> still no cnt_vld.
- Basic window (WIN_FRAMES=16): en=1, 16 frames each with dx=+5, dy=-3, then frame_start -> one cycle later dxo_cnt=16, dxn_cnt=0, dyo_cnt=0, dyn_cnt=16, x_same=0, y_same=0, cnt_vld high for 1 cycle.
- Dead zone and extremes: dx=+2, -2, 0 (ignored); dx=-128 -> dxn_cnt=1 and mag_xn=128; dx=+127 -> dxo_cnt=1. x_same=0 since |127-128|=1 exceeds 0 when SAME_TOL=0, and x_same=1 with SAME_TOL=1.
- Saturation: 40 meas_vld with dy=+10 in one window -> dyo_cnt=31; the next window starts from 0.
- Same flag: dx=+9 then dx=-10 in the window -> x_same=1. A window with only positive x -> x_same=0.
- en drop mid-window: 5 frames of events, en=0, en=1, then 16 full frames -> first cnt_vld after re-arm reflects only the new window; outputs held during the gap.

Source files
------------

// File: rtl/shift_count.sv
// Per-axis motion-event accumulator: classifies signed dx/dy samples and
// publishes saturated per-direction event counts plus same-magnitude flags once per window.
module shift_count #(
  parameter int unsigned DW         = 8,
  parameter int unsigned DEAD_ZONE  = 2,
  parameter int unsigned SAME_TOL   = 1,
  parameter int unsigned WIN_FRAMES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          frame_start,
  input  logic          meas_vld,
  input  logic [DW-1:0] dx,
  input  logic [DW-1:0] dy,
  output logic [4:0]    dxo_cnt,
  output logic [4:0]    dxn_cnt,
  output logic [4:0]    dyo_cnt,
  output logic [4:0]    dyn_cnt,
  output logic          x_same,
  output logic          y_same,
  output logic          cnt_vld
);

  localparam int unsigned CW = 5;
  localparam int unsigned MW = DW + 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [MW-1:0] DZ      = MW'(DEAD_ZONE);
  localparam logic [MW-1:0] TOL     = MW'(SAME_TOL);
  localparam logic [CW-1:0] WIN     = CW'(WIN_FRAMES);

  typedef enum logic [1:0] {IDLE, ARM, ACCUM} state_t;

  state_t state, state_nx;
  logic open_win, close_win, adv_frame, drop_win;

  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] acc_xo, acc_xn, acc_yo, acc_yn;
  logic [CW-1:0] acc_xo_nx, acc_xn_nx, acc_yo_nx, acc_yn_nx;
  logic [MW-1:0] mag_xo, mag_xn, mag_yo, mag_yn;
  logic [MW-1:0] mag_xo_nx, mag_xn_nx, mag_yo_nx, mag_yn_nx;
  logic [MW-1:0] mag_x, mag_y;
  logic          take, ev_x, ev_y, xo_ev, xn_ev, yo_ev, yn_ev;

  // Magnitude in one extra bit so the most negative input maps to its true size.
  function automatic logic [MW-1:0] abs_ext(input logic [DW-1:0] d);
    logic [MW-1:0] e;
    e = {d[DW-1], d};
    return d[DW-1] ? MW'(~e + MW'(1)) : e;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + CW'(1);
  endfunction

  function automatic logic same_mag(input logic [MW-1:0] p, input logic [MW-1:0] n);
    logic [MW-1:0] diff;
    diff = (p >= n) ? p - n : n - p;
    return (p != '0) && (n != '0) && (diff <= TOL);
  endfunction

  // Sample classification; x and y are independent.
  assign take  = (state == ACCUM) && en && meas_vld;
  assign mag_x = abs_ext(dx);
  assign mag_y = abs_ext(dy);
  assign ev_x  = mag_x > DZ;
  assign ev_y  = mag_y > DZ;
  assign xo_ev = take && ev_x && !dx[DW-1];
  assign xn_ev = take && ev_x &&  dx[DW-1];
  assign yo_ev = take && ev_y && !dy[DW-1];
  assign yn_ev = take && ev_y &&  dy[DW-1];

  assign acc_xo_nx = xo_ev ? sat_inc(acc_xo) : acc_xo;
  assign acc_xn_nx = xn_ev ? sat_inc(acc_xn) : acc_xn;
  assign acc_yo_nx = yo_ev ? sat_inc(acc_yo) : acc_yo;
  assign acc_yn_nx = yn_ev ? sat_inc(acc_yn) : acc_yn;
  assign mag_xo_nx = xo_ev ? mag_x : mag_xo;
  assign mag_xn_nx = xn_ev ? mag_x : mag_xn;
  assign mag_yo_nx = yo_ev ? mag_y : mag_yo;
  assign mag_yn_nx = yn_ev ? mag_y : mag_yn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and window control strobes; en low wins over everything.
  always_comb begin
    state_nx  = state;
    open_win  = 1'b0;
    close_win = 1'b0;
    adv_frame = 1'b0;
    drop_win  = 1'b0;
    case (state)
      IDLE: if (en) state_nx = ARM;
      ARM: begin
        if (!en) begin
          state_nx = IDLE;
        end else if (frame_start) begin
          state_nx = ACCUM;
          open_win = 1'b1;
        end
      end
      ACCUM: begin
        if (!en) begin
          state_nx = IDLE;
          drop_win = 1'b1;
        end else if (frame_start) begin
          if (frame_cnt == WIN) close_win = 1'b1;
          else                  adv_frame = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Accumulators, last magnitudes, frame counter and published outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      acc_xo    <= '0;
      acc_xn    <= '0;
      acc_yo    <= '0;
      acc_yn    <= '0;
      mag_xo    <= '0;
      mag_xn    <= '0;
      mag_yo    <= '0;
      mag_yn    <= '0;
      dxo_cnt   <= '0;
      dxn_cnt   <= '0;
      dyo_cnt   <= '0;
      dyn_cnt   <= '0;
      x_same    <= 1'b0;
      y_same    <= 1'b0;
      cnt_vld   <= 1'b0;
    end else begin
      cnt_vld <= close_win;
      if (open_win || drop_win || close_win) begin
        frame_cnt <= drop_win ? CW'(0) : CW'(1);
        acc_xo    <= '0;
        acc_xn    <= '0;
        acc_yo    <= '0;
        acc_yn    <= '0;
        mag_xo    <= '0;
        mag_xn    <= '0;
        mag_yo    <= '0;
        mag_yn    <= '0;
      end else begin
        acc_xo <= acc_xo_nx;
        acc_xn <= acc_xn_nx;
        acc_yo <= acc_yo_nx;
        acc_yn <= acc_yn_nx;
        mag_xo <= mag_xo_nx;
        mag_xn <= mag_xn_nx;
        mag_yo <= mag_yo_nx;
        mag_yn <= mag_yn_nx;
        if (adv_frame) frame_cnt <= frame_cnt + CW'(1);
      end
      // Publish includes any event landing in the closing cycle.
      if (close_win) begin
        dxo_cnt <= acc_xo_nx;
        dxn_cnt <= acc_xn_nx;
        dyo_cnt <= acc_yo_nx;
        dyn_cnt <= acc_yn_nx;
        x_same  <= same_mag(mag_xo_nx, mag_xn_nx);
        y_same  <= same_mag(mag_yo_nx, mag_yn_nx);
      end
    end
  end

endmodule

// File: tb/tb_shift_count.sv
// Self-checking bench for shift_count: directed scenarios plus randomized windows
// against a counting reference model; a second instance runs with zero tolerance.
module tb_shift_count;

  localparam int DZ  = 2;
  localparam int WIN = 16;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       frame_start;
  logic       meas_vld;
  logic [7:0] dx;
  logic [7:0] dy;
  logic [4:0] dxo_cnt, dxn_cnt, dyo_cnt, dyn_cnt;
  logic       x_same, y_same, cnt_vld;
  logic [4:0] dxo_cnt0, dxn_cnt0, dyo_cnt0, dyn_cnt0;
  logic       x_same0, y_same0, cnt_vld0;
  logic [22:0] obs, obs0;

  int tests_run;
  int tests_failed;

  int m_xo, m_xn, m_yo, m_yn;
  int lm_xo, lm_xn, lm_yo, lm_yn;
  logic [22:0] exp_hold, exp_hold0;

  shift_count #(.DW(8), .DEAD_ZONE(2), .SAME_TOL(1), .WIN_FRAMES(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .frame_start(frame_start), .meas_vld(meas_vld),
    .dx(dx), .dy(dy), .dxo_cnt(dxo_cnt), .dxn_cnt(dxn_cnt), .dyo_cnt(dyo_cnt),
    .dyn_cnt(dyn_cnt), .x_same(x_same), .y_same(y_same), .cnt_vld(cnt_vld)
  );

  shift_count #(.DW(8), .DEAD_ZONE(2), .SAME_TOL(0), .WIN_FRAMES(16)) dut_t0 (
    .clk(clk), .rst_n(rst_n), .en(en), .frame_start(frame_start), .meas_vld(meas_vld),
    .dx(dx), .dy(dy), .dxo_cnt(dxo_cnt0), .dxn_cnt(dxn_cnt0), .dyo_cnt(dyo_cnt0),
    .dyn_cnt(dyn_cnt0), .x_same(x_same0), .y_same(y_same0), .cnt_vld(cnt_vld0)
  );

  assign obs  = {dxo_cnt, dxn_cnt, dyo_cnt, dyn_cnt, x_same, y_same, cnt_vld};
  assign obs0 = {dxo_cnt0, dxn_cnt0, dyo_cnt0, dyn_cnt0, x_same0, y_same0, cnt_vld0};

  always #5 clk = ~clk;

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sat(int c);
    return (c > 31) ? 31 : c;
  endfunction

  function automatic logic same(int p, int n, int tol);
    return (p != 0) && (n != 0) && (iabs(p - n) <= tol);
  endfunction

  function automatic int rnd_d();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 255)) - 128;
    return int'($urandom_range(0, 24)) - 12;
  endfunction

  task automatic model_clear();
    m_xo = 0; m_xn = 0; m_yo = 0; m_yn = 0;
    lm_xo = 0; lm_xn = 0; lm_yo = 0; lm_yn = 0;
  endtask

  task automatic model_sample(int x, int y);
    if (iabs(x) > DZ) begin
      if (x > 0) begin m_xo++; lm_xo = iabs(x); end
      else       begin m_xn++; lm_xn = iabs(x); end
    end
    if (iabs(y) > DZ) begin
      if (y > 0) begin m_yo++; lm_yo = iabs(y); end
      else       begin m_yn++; lm_yn = iabs(y); end
    end
  endtask

  function automatic logic [22:0] exp_vec(logic cv, int tol);
    return {5'(sat(m_xo)), 5'(sat(m_xn)), 5'(sat(m_yo)), 5'(sat(m_yn)),
            same(lm_xo, lm_xn, tol), same(lm_yo, lm_yn, tol), cv};
  endfunction

  task automatic drive(logic fs, logic vld, int x, int y);
    frame_start = fs;
    meas_vld    = vld;
    dx          = 8'(x);
    dy          = 8'(y);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    meas_vld    = 1'b0;
  endtask

  // From IDLE: enable, then the first frame_start opens frame 1.
  task automatic arm();
    en = 1'b1;
    drive(1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 0, 0);
    model_clear();
  endtask

  task automatic finish_frames(int from);
    for (int f = from + 1; f <= WIN; f++) drive(1'b1, 1'b0, 0, 0);
  endtask

  task automatic drop();
    en = 1'b0;
    drive(1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b1, rnd_d(), rnd_d());
      tests_run++;
      if (obs !== 23'd0 || obs0 !== 23'd0) begin
        tests_failed++;
        $display("FAIL reset_hold: got %h/%h expected 0", obs, obs0);
      end
    end
    en    = 1'b0;
    rst_n = 1'b1;
    for (int f = 0; f < 40; f++) begin
      drive(1'b1, 1'b1, rnd_d(), rnd_d());
      drive(1'b0, 1'b1, rnd_d(), rnd_d());
      tests_run++;
      if (obs !== 23'd0) begin
        tests_failed++;
        $display("FAIL idle_no_publish frame %0d: got %h expected 0", f, obs);
      end
    end
  endtask

  task automatic test_basic_window();
    arm();
    for (int f = 1; f <= WIN; f++) begin
      if (f > 1) drive(1'b1, 1'b0, 0, 0);
      drive(1'b0, 1'b1, 5, -3);
      model_sample(5, -3);
    end
    drive(1'b1, 1'b0, 0, 0);
    tests_run++;
    if (obs !== exp_vec(1'b1, 1)) begin
      tests_failed++;
      $display("FAIL basic_close: got %h expected %h", obs, exp_vec(1'b1, 1));
    end
    exp_hold  = exp_vec(1'b0, 1);
    exp_hold0 = exp_vec(1'b0, 0);
    model_clear();
    drive(1'b0, 1'b0, 0, 0);
    tests_run++;
    if (obs !== exp_hold) begin
      tests_failed++;
      $display("FAIL basic_pulse_one_cycle: got %h expected %h", obs, exp_hold);
    end
    drop();
  endtask

  task automatic test_dead_zone();
    int xs[5] = '{2, -2, 0, -128, 127};
    int ys[5] = '{0, 2, -2, 3, -3};
    arm();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, xs[i], ys[i]);
      model_sample(xs[i], ys[i]);
    end
    finish_frames(1);
    drive(1'b1, 1'b0, 0, 0);
    tests_run++;
    if (obs !== exp_vec(1'b1, 1)) begin
      tests_failed++;
      $display("FAIL deadzone_tol1: got %h expected %h", obs, exp_vec(1'b1, 1));
    end
    tests_run++;
    if (obs0 !== exp_vec(1'b1, 0)) begin
      tests_failed++;
      $display("FAIL deadzone_tol0: got %h expected %h", obs0, exp_vec(1'b1, 0));
    end
    exp_hold  = exp_vec(1'b0, 1);
    exp_hold0 = exp_vec(1'b0, 0);
    drop();
    tests_run++;
    if (obs !== exp_hold) begin
      tests_failed++;
      $display("FAIL deadzone_hold_after_drop: got %h expected %h", obs, exp_hold);
    end
  endtask

  task automatic test_saturation();
    arm();
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, 0, 10);
      model_sample(0, 10);
    end
    finish_frames(1);
    drive(1'b1, 1'b0, 0, 0);
    tests_run++;
    if (obs !== exp_vec(1'b1, 1) || dyo_cnt !== 5'd31) begin
      tests_failed++;
      $display("FAIL saturate: got %h expected %h", obs, exp_vec(1'b1, 1));
    end
    model_clear();
    drive(1'b0, 1'b1, 0, 10);
    model_sample(0, 10);
    finish_frames(1);
    drive(1'b1, 1'b0, 0, 0);
    tests_run++;
    if (obs !== exp_vec(1'b1, 1)) begin
      tests_failed++;
      $display("FAIL saturate_next_window: got %h expected %h", obs, exp_vec(1'b1, 1));
    end
    exp_hold  = exp_vec(1'b0, 1);
    exp_hold0 = exp_vec(1'b0, 0);
    drop();
  endtask

  task automatic test_same_flag();
    arm();
    drive(1'b0, 1'b1, 9, 0);   model_sample(9, 0);
    drive(1'b0, 1'b1, -10, 0); model_sample(-10, 0);
    finish_frames(1);
    drive(1'b1, 1'b0, 0, 0);
    tests_run++;
    if (obs !== exp_vec(1'b1, 1) || x_same !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_match: got %h expected %h", obs, exp_vec(1'b1, 1));
    end
    model_clear();
    drive(1'b0, 1'b1, 9, 0);  model_sample(9, 0);
    drive(1'b0, 1'b1, 20, 0); model_sample(20, 0);
    finish_frames(1);
    drive(1'b1, 1'b0, 0, 0);
    tests_run++;
    if (obs !== exp_vec(1'b1, 1) || x_same !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_pos_only: got %h expected %h", obs, exp_vec(1'b1, 1));
    end
    exp_hold  = exp_vec(1'b0, 1);
    exp_hold0 = exp_vec(1'b0, 0);
    drop();
  endtask

  task automatic test_en_drop();
    arm();
    for (int f = 1; f <= 5; f++) begin
      if (f > 1) drive(1'b1, 1'b0, 0, 0);
      drive(1'b0, 1'b1, 7, -7);
    end
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b1, rnd_d(), rnd_d());
      tests_run++;
      if (obs !== exp_hold) begin
        tests_failed++;
        $display("FAIL en_drop_hold cycle %0d: got %h expected %h", i, obs, exp_hold);
      end
    end
    arm();
    for (int f = 1; f <= WIN; f++) begin
      if (f > 1) drive(1'b1, 1'b0, 0, 0);
      drive(1'b0, 1'b1, 0, -20);
      model_sample(0, -20);
    end
    drive(1'b1, 1'b0, 0, 0);
    tests_run++;
    if (obs !== exp_vec(1'b1, 1)) begin
      tests_failed++;
      $display("FAIL en_drop_new_window: got %h expected %h", obs, exp_vec(1'b1, 1));
    end
    exp_hold  = exp_vec(1'b0, 1);
    exp_hold0 = exp_vec(1'b0, 0);
    drop();
  endtask

  // Continuous windows with samples on frame_start cycles, including the closing one.
  task automatic test_back_to_back();
    int x, y;
    logic v;
    arm();
    for (int w = 0; w < 5; w++) begin
      for (int f = 1; f <= WIN; f++) begin
        if (f > 1) begin
          v = 1'($urandom_range(0, 1)); x = rnd_d(); y = rnd_d();
          drive(1'b1, v, x, y);
          if (v) model_sample(x, y);
        end
        for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
          v = 1'($urandom_range(0, 1)); x = rnd_d(); y = rnd_d();
          drive(1'b0, v, x, y);
          if (v) model_sample(x, y);
        end
      end
      v = 1'($urandom_range(0, 1)); x = rnd_d(); y = rnd_d();
      drive(1'b1, v, x, y);
      if (v) model_sample(x, y);
      tests_run++;
      if (obs !== exp_vec(1'b1, 1)) begin
        tests_failed++;
        $display("FAIL random_window %0d: got %h expected %h", w, obs, exp_vec(1'b1, 1));
      end
      tests_run++;
      if (obs0 !== exp_vec(1'b1, 0)) begin
        tests_failed++;
        $display("FAIL random_window_tol0 %0d: got %h expected %h", w, obs0, exp_vec(1'b1, 0));
      end
      exp_hold  = exp_vec(1'b0, 1);
      exp_hold0 = exp_vec(1'b0, 0);
      model_clear();
    end
    drop();
    tests_run++;
    if (obs !== exp_hold || obs0 !== exp_hold0) begin
      tests_failed++;
      $display("FAIL random_final_hold: got %h/%h expected %h/%h", obs, obs0, exp_hold, exp_hold0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk          = 1'b0;
    rst_n        = 1'b0;
    en           = 1'b0;
    frame_start  = 1'b0;
    meas_vld     = 1'b0;
    dx           = '0;
    dy           = '0;
    tests_run    = 0;
    tests_failed = 0;
    exp_hold     = '0;
    exp_hold0    = '0;
    model_clear();
    test_reset();
    test_basic_window();
    test_dead_zone();
    test_saturation();
    test_same_flag();
    test_en_drop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
